// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared multiplier constants and op encodings
package mul_pkg;

    localparam int XLEN = 64;
    localparam int COLS = 132;

    typedef enum logic [2:0] {
        MUL_OP_MUL    = 3'd0,
        MUL_OP_MULH   = 3'd1,
        MUL_OP_MULHSU = 3'd2,
        MUL_OP_MULHU  = 3'd3,
        MUL_OP_MULW   = 3'd4
    } mul_op_e;

endpackage

// File: rtl/mul_add64.sv
// rtl/mul_add64.sv - carry-propagate adder with carry-in and carry-out
module mul_add64 #(
    parameter int W = 64
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    output logic [W-1:0] o_sum,
    output logic         o_co
);

    assign {o_co, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_ci};

endmodule

// File: rtl/mul_result_stage.sv
// rtl/mul_result_stage.sv - resolves Wallace S/C vectors in two pipelined halves
module mul_result_stage #(
    parameter int XLEN = mul_pkg::XLEN,
    parameter int COLS = mul_pkg::COLS
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    input  logic [COLS-1:0] io_in_s,
    input  logic [COLS-1:0] io_in_c,
    input  logic [2:0]      io_in_op,
    input  logic [4:0]      io_in_rd,
    input  logic            io_flush,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [XLEN-1:0] io_out_result,
    output logic [4:0]      io_out_rd
);
    import mul_pkg::*;

    logic            r_s1_valid;
    logic [XLEN-1:0] r_lo;
    logic            r_lo_carry;
    logic [XLEN-1:0] r_s_hi;
    logic [XLEN-1:0] r_c_hi;
    logic [2:0]      r_op;
    logic [4:0]      r_s1_rd;

    logic            r_s2_valid;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd;

    logic            w_s2_adv;
    logic            w_s1_adv;
    logic            w_in_fire;
    logic [XLEN-1:0] w_lo_sum;
    logic            w_lo_co;
    logic [XLEN-1:0] w_hi_sum;
    logic            w_hi_co;
    logic [XLEN-1:0] w_result;
    logic            w_unused;

    assign w_s2_adv    = !r_s2_valid || io_out_ready;
    assign w_s1_adv    = r_s1_valid && w_s2_adv;
    assign io_in_ready = (!r_s1_valid || w_s2_adv) && !io_flush;
    assign w_in_fire   = io_in_valid && io_in_ready;

    // Column i of C carries weight 2^(i+1), hence the one-bit offset on both halves.
    mul_add64 #(.W(XLEN)) u_add_lo (
        .i_a   (io_in_s[XLEN-1:0]),
        .i_b   ({io_in_c[XLEN-2:0], 1'b0}),
        .i_ci  (1'b0),
        .o_sum (w_lo_sum),
        .o_co  (w_lo_co)
    );

    mul_add64 #(.W(XLEN)) u_add_hi (
        .i_a   (r_s_hi),
        .i_b   (r_c_hi),
        .i_ci  (r_lo_carry),
        .o_sum (w_hi_sum),
        .o_co  (w_hi_co)
    );

    // Product is modulo 2^128: upper columns and the final carry are dropped.
    assign w_unused = ^{io_in_s[COLS-1:2*XLEN], io_in_c[COLS-1:2*XLEN-1], w_hi_co};

    always_comb begin
        w_result = '0;
        case (r_op)
            MUL_OP_MUL:    w_result = r_lo;
            MUL_OP_MULH,
            MUL_OP_MULHSU,
            MUL_OP_MULHU:  w_result = w_hi_sum;
            MUL_OP_MULW:   w_result = {{(XLEN-32){r_lo[31]}}, r_lo[31:0]};
            default:       w_result = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_lo       <= '0;
            r_lo_carry <= 1'b0;
            r_s_hi     <= '0;
            r_c_hi     <= '0;
            r_op       <= '0;
            r_s1_rd    <= '0;
        end else if (io_flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_lo       <= w_lo_sum;
            r_lo_carry <= w_lo_co;
            r_s_hi     <= io_in_s[2*XLEN-1:XLEN];
            r_c_hi     <= io_in_c[2*XLEN-2:XLEN-1];
            r_op       <= io_in_op;
            r_s1_rd    <= io_in_rd;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_rd       <= '0;
        end else if (io_flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_result   <= w_result;
            r_rd       <= r_s1_rd;
        end else if (io_out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign io_out_valid  = r_s2_valid;
    assign io_out_result = r_result;
    assign io_out_rd     = r_rd;

endmodule

// File: doc/mul_result_stage.md
# mul_result_stage

Final stage of the 64-bit Wallace-tree multiplier, directly downstream of the 132-column compressor array. Each column delivers a sum bit and a carry-out bit. This block registers the resulting sum vector S and carry vector C and resolves S + (C << 1) with a two-cycle pipelined carry-propagate add (low half, then high half). It then selects and formats the 64-bit result per multiply op and returns it to the execute unit over a valid/ready handshake, with flush support.

## Interface
Parameters:
- XLEN, 64, result width
- COLS, 132, compressor column count (bits above 127 are discarded)

Ports:
- clock  in  1  sole clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- io_in_valid  in  1  S/C/op/rd valid
- io_in_ready  out  1  stage accepts this cycle
- io_in_s  in  COLS  column sum bits; bit i = column i
- io_in_c  in  COLS  column carry-outs; bit i carries weight 2^(i+1)
- io_in_op  in  3  MUL=0, MULH=1, MULHSU=2, MULHU=3, MULW=4; 5–7 reserved
- io_in_rd  in  5  destination tag, passed through untouched
- io_flush  in  1  kill all in-flight operations
- io_out_valid  out  1  result valid
- io_out_ready  in  1  consumer accepts
- io_out_result  out  XLEN  formatted product
- io_out_rd  out  5  tag of io_out_result

## Operation
- Transfers occur only when valid && ready on the same edge. Input and output are independent.
- Stage 1 (s1), on accept:
  - lo = S[63:0] + {C[62:0],1'b0}, as a 65-bit value.
  - Register lo[63:0], carry lo[64], S[127:64], C[126:63], op and rd. Set s1_valid.
- Stage 2 (s2), on s1 advance:
  - hi = S[127:64] + C[126:63] + carry, modulo 2^64.
  - Format the result and register it with rd. Set s2_valid.
- Result format:
  - MUL: lo[63:0]
  - MULH, MULHSU, MULHU: hi (sign handling is already folded into the partial products upstream)
  - MULW: sign-extend lo[31:0] to 64 bits
  - Reserved ops: result 0, still completed (not dropped)
- Arithmetic is modulo 2^128. S[131:128] and C[131:127] are ignored.
- Flow control:
  - s2 advance = !s2_valid || io_out_ready
  - s1 advance = s1_valid && s2 advance
  - io_in_ready = (!s1_valid || s2 advance) && !io_flush
  - io_out_valid = s2_valid
- Flush: on the edge where io_flush=1, s1_valid and s2_valid clear. No new input is accepted that cycle. A result presented in the same cycle as flush is treated as not transferred, even if io_out_ready=1.
- Reset (async): s1_valid=0, s2_valid=0, io_out_result=0, io_out_rd=0, and all datapath registers 0. Asserting reset mid-operation discards all in-flight operations. After reset deasserts, io_in_ready=1 in the first cycle.

## Timing
- Latency: an input accepted at edge N gives io_out_valid=1 in the cycle after edge N+1, i.e. two cycles, provided there is no backpressure.
- Throughput: one operation per cycle while io_out_ready=1.
- Buffering: at most 2 operations in flight. With io_out_ready held low, io_in_ready falls after the second accept.
- Ordering: results leave in acceptance order.
- Stability: io_out_result and io_out_rd hold stable while io_out_valid=1 && !io_out_ready.
- Simultaneous output accept and input accept when full: legal and lossless (pipeline shifts).
- No combinational path from io_in_* to io_out_*. io_in_ready depends combinationally on io_out_ready and io_flush only.

## Structure
- Shared package mul_pkg:
  - op encodings MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU, MUL_OP_MULW
  - XLEN and COLS constants
  - reused by the compressor array and the Booth partial-product generator
- Sub-module mul_add64: 64-bit adder with carry-in and carry-out, instantiated once per stage.
- Control is two valid bits; no explicit FSM.

## Test plan
- MUL low product: S=15, C=0, op=MUL, rd=7 → two cycles later io_out_valid=1, result=0x000000000000000F, rd=7.
- Carry across the half boundary: S[63:0]=0xFFFFFFFFFFFFFFFF, S[127:64]=0, C=1 (bit 0), op=MULHU → result=0x0000000000000001. Same input with op=MUL → result=0x0000000000000001.
- MULW sign extension: S=0x80000000, C=0, op=MULW → result=0xFFFFFFFF80000000. S=0x7FFFFFFF → result=0x000000007FFFFFFF.
- Backpressure: io_out_ready=0 for 5 cycles while driving 3 back-to-back inputs (rd 1,2,3) → io_in_ready drops after rd 1 and 2 are accepted; on release, rd 1,2,3 emerge in order with stable data during the stall.
- Flush: accept rd 4 and rd 5 on consecutive edges, then pulse io_flush one cycle → io_out_valid=0 next cycle and neither tag appears. An input offered during the flush cycle sees io_in_ready=0.
- Async reset mid-flight: with 2 operations in flight, assert reset between edges → io_out_valid, io_out_result and io_out_rd go to 0 immediately (before the next edge). After release, a fresh MUL (S=2, C=1) yields result 4.
